// File: rtl/argmax_pkg.sv
// Shared types and constants for the argmax layer cells.
package argmax_pkg;

    typedef enum logic [0:0] {
        StAccum,
        StDone
    } argmax_state_e;

    localparam int unsigned DefaultDataWidth  = 32;
    localparam int unsigned DefaultIndexWidth = 32;

    // Width needed to hold an element count from 0 up to len inclusive.
    function automatic int unsigned cnt_width(input int unsigned len);
        return $clog2(len + 1);
    endfunction

endpackage

// File: rtl/argmax_stream_unit_if.sv
// Element input stream and result output stream of the argmax unit.
interface argmax_stream_unit_if #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned INDEX_WIDTH = 32,
    parameter int unsigned LEN_WIDTH   = 4
) ();

    logic [INDEX_WIDTH-1:0] input_index;
    logic [DATA_WIDTH-1:0]  input_value;
    logic                   input_valid;
    logic                   input_last;
    logic                   input_ready;
    logic [INDEX_WIDTH-1:0] output_index;
    logic [DATA_WIDTH-1:0]  output_value;
    logic [LEN_WIDTH-1:0]   output_length;
    logic                   output_valid;
    logic                   output_ready;

    // Unit side: consumes elements, produces results.
    modport slave (
        input  input_index, input_value, input_valid, input_last, output_ready,
        output input_ready, output_index, output_value, output_length, output_valid
    );

    // Environment side: produces elements, consumes results.
    modport master (
        output input_index, input_value, input_valid, input_last, output_ready,
        input  input_ready, output_index, output_value, output_length, output_valid
    );

endinterface

// File: rtl/argmax_compare.sv
// Strict greater-than compare with selectable signed/unsigned ordering.
module argmax_compare #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter bit          SIGNED     = 1'b0
) (
    input  logic [DATA_WIDTH-1:0] candidate_i,
    input  logic [DATA_WIDTH-1:0] best_i,
    output logic                  greater_o
);

    // Strictly greater only, so ties keep the incumbent.
    always_comb begin
        if (SIGNED) begin
            greater_o = $signed(candidate_i) > $signed(best_i);
        end else begin
            greater_o = candidate_i > best_i;
        end
    end

endmodule

// File: rtl/argmax_stream_unit.sv
// Streaming argmax: tracks the running maximum of a vector and emits index, value, length.
module argmax_stream_unit
    import argmax_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = DefaultDataWidth,
    parameter int unsigned INDEX_WIDTH   = DefaultIndexWidth,
    parameter int unsigned VECTOR_LENGTH = 10,
    parameter bit          SIGNED        = 1'b0
) (
    input logic                  clk,
    input logic                  rst,
    argmax_stream_unit_if.slave  bus
);

    localparam int unsigned CountWidth = cnt_width(VECTOR_LENGTH);
    localparam logic [CountWidth-1:0] LastCount = CountWidth'(VECTOR_LENGTH - 1);

    argmax_state_e          state_q, state_d;
    logic [CountWidth-1:0]  count_q, count_d;
    logic [INDEX_WIDTH-1:0] best_index_q, best_index_d;
    logic [DATA_WIDTH-1:0]  best_value_q, best_value_d;
    logic [INDEX_WIDTH-1:0] out_index_q, out_index_d;
    logic [DATA_WIDTH-1:0]  out_value_q, out_value_d;
    logic [CountWidth-1:0]  out_length_q, out_length_d;
    logic                   out_valid_q, out_valid_d;

    logic                   greater;
    logic                   take;
    logic [INDEX_WIDTH-1:0] upd_index;
    logic [DATA_WIDTH-1:0]  upd_value;

    argmax_compare #(
        .DATA_WIDTH (DATA_WIDTH),
        .SIGNED     (SIGNED)
    ) u_compare (
        .candidate_i (bus.input_value),
        .best_i      (best_value_q),
        .greater_o   (greater)
    );

    // Best-so-far including the element currently presented; first element always wins.
    always_comb begin
        take      = (count_q == '0) || greater;
        upd_index = take ? bus.input_index : best_index_q;
        upd_value = take ? bus.input_value : best_value_q;
    end

    // Next-state: accumulate in StAccum, hold the result in StDone until taken.
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        best_index_d = best_index_q;
        best_value_d = best_value_q;
        out_index_d  = out_index_q;
        out_value_d  = out_value_q;
        out_length_d = out_length_q;
        out_valid_d  = out_valid_q;
        unique case (state_q)
            StAccum: begin
                if (bus.input_valid) begin
                    count_d      = count_q + CountWidth'(1);
                    best_index_d = upd_index;
                    best_value_d = upd_value;
                    if (bus.input_last || (count_q == LastCount)) begin
                        state_d      = StDone;
                        out_index_d  = upd_index;
                        out_value_d  = upd_value;
                        out_length_d = count_q + CountWidth'(1);
                        out_valid_d  = 1'b1;
                    end
                end
            end
            StDone: begin
                if (out_valid_q && bus.output_ready) begin
                    state_d      = StAccum;
                    out_valid_d  = 1'b0;
                    count_d      = '0;
                    best_index_d = '0;
                    best_value_d = '0;
                end
            end
            default: state_d = StAccum;
        endcase
    end

    // State and datapath registers; reset drops any partial vector or pending result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StAccum;
            count_q      <= '0;
            best_index_q <= '0;
            best_value_q <= '0;
            out_index_q  <= '0;
            out_value_q  <= '0;
            out_length_q <= '0;
            out_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            best_index_q <= best_index_d;
            best_value_q <= best_value_d;
            out_index_q  <= out_index_d;
            out_value_q  <= out_value_d;
            out_length_q <= out_length_d;
            out_valid_q  <= out_valid_d;
        end
    end

    // Ready is forced low during reset even though the reset state is StAccum.
    assign bus.input_ready   = (state_q == StAccum) && !rst;
    assign bus.output_index  = out_index_q;
    assign bus.output_value  = out_value_q;
    assign bus.output_length = out_length_q;
    assign bus.output_valid  = out_valid_q;

endmodule
